// File: rtl/rom_pkg.sv
// rom_pkg: scanner state encodings and default ROM geometry, shared with memory_ROM users.
package rom_pkg;
    localparam int ROM_ADDR_WIDTH = 2;
    localparam int ROM_DATA_WIDTH = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/rom_scanner.sv
// rom_scanner: walks an external ROM once per start, streams each byte over a
// valid/ready handshake and accumulates a modulo-2**DATA_WIDTH checksum.
module rom_scanner
    import rom_pkg::*;
#(
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  chip_selection,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_cs;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  w_at_max;
    logic                  w_hs;

    assign w_at_max = r_addr == ADDR_MAX;
    assign w_hs     = r_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cs    <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_SETUP;
                    r_addr  <= '0;
                    r_cs    <= 1'b1;
                    r_sum   <= '0;
                end
                ST_SETUP: begin
                    r_data  <= rom_data;
                    r_sum   <= r_sum + rom_data;
                    r_valid <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: if (w_hs) begin
                    r_valid <= 1'b0;
                    // address stops at max so it stays visible through DONE
                    r_addr  <= w_at_max ? r_addr : r_addr + 1'b1;
                    r_cs    <= !w_at_max;
                    r_state <= w_at_max ? ST_DONE : ST_SETUP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign address        = r_addr;
    assign chip_selection = r_cs;
    assign out_data       = r_data;
    assign out_valid      = r_valid;
    assign out_last       = r_valid && w_at_max;
    assign checksum       = r_sum;
    assign busy           = r_state != ST_IDLE;
    assign done           = r_state == ST_DONE;
endmodule

// File: tb/tb_rom_scanner.sv
// tb_rom_scanner: randomized scans against a ROM array model, with stalls,
// ignored start pulses, mid-scan reset and back-to-back scans.
module tb_rom_scanner;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] address;
    logic          chip_selection;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] checksum;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom [N];
    int n_checks = 0;
    int n_pass   = 0;

    assign rom_data = rom[address];

    always #5 clk = ~clk;

    rom_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .address(address),
        .chip_selection(chip_selection), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .checksum(checksum), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rom_sum();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < N; i++) s += rom[i];
        return s;
    endfunction

    task automatic load_rom(input logic [DW-1:0] a, b, c, d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    // stall < 0 picks a random 0..4 stall per byte; poke fires stray starts mid-scan
    task automatic run_scan(input int stall, input bit poke);
        int got = 0, cyc = 0, dones = 0, done_at = -1, wait_n = 0;
        bit pend = 0;
        logic [DW-1:0] held = '0, sum = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (dones == 0 && cyc < 400) begin
            start = 1'b0;
            if (done) begin
                dones++;
                done_at = cyc;
            end else begin
                if (out_valid) begin
                    if (!pend) begin
                        pend = 1;
                        held = out_data;
                        wait_n = stall < 0 ? int'($urandom_range(0, 4)) : stall;
                    end else check("stall_hold", out_data, held);
                    check("cs_active", chip_selection, 1'b1);
                    out_ready = wait_n == 0;
                    if (wait_n > 0) wait_n--;
                    if (out_ready) begin
                        if (got < N) begin
                            sum += rom[got];
                            check("byte", out_data, rom[got]);
                            check("addr", address, got);
                            check("last", out_last, got == N - 1);
                            check("sum_run", checksum, sum);
                        end else check("extra_byte", got, N - 1);
                        pend = 0;
                        got++;
                    end
                end else out_ready = 1'($urandom_range(0, 1));
                start = poke && busy && ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", dones, 1);
        check("byte_count", got, N);
        if (stall == 0) check("done_cycle", done_at, 2 * N + 1);
        check("checksum", checksum, rom_sum());
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_cs", chip_selection, 1'b0);
        check("addr_hold", address, N - 1);
        check("sum_hold", checksum, rom_sum());
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        load_rom(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) @(negedge clk);
        check("rst_outs", {address, chip_selection, out_data, out_valid, out_last, checksum, busy, done}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, done, out_valid}, 0);

        run_scan(0, 0);
        run_scan(3, 0);
        load_rom(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_scan(0, 0);
        check("wrap_sum", checksum, rom_sum());
        load_rom(8'h11, 8'h22, 8'h33, 8'h44);
        run_scan(0, 1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        k = 0;
        while (!(out_valid && address == 2) && k < 50) begin
            out_ready = out_valid;
            @(negedge clk);
            out_ready = 1'b0;
            k++;
        end
        check("reach_addr2", k < 50, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_outs", {address, chip_selection, out_data, out_valid, out_last, checksum, busy, done}, 0);
        @(negedge clk);
        check("midrst_done", done, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abandon", {busy, done}, 0);
        end
        run_scan(0, 0);

        load_rom(8'h01, 8'h02, 8'h03, 8'h04);
        run_scan(0, 0);
        for (int s = 0; s < 6; s++) begin
            load_rom(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            run_scan(-1, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
